// File: rtl/nl_vc_buffers_param.sv
// Input-port VC buffer: N_VC circular FIFOs, binary-addressed push, per-VC pop, one-hot read select.
// Flags come straight from registered counts; credits and sticky errors are registered one edge later.
module nl_vc_buffers_param #(
  parameter  int N_VC   = 4,
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 64,
  parameter  int NF_TH  = 1,
  localparam int VW     = $clog2(N_VC),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [VW-1:0]        vc_id,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [N_VC-1:0]      pop,
  input  logic [N_VC-1:0]      select,
  output logic [DATA_W-1:0]    data_out,
  output logic [N_VC-1:0]      empty,
  output logic [N_VC-1:0]      nearly_empty,
  output logic [N_VC-1:0]      full,
  output logic [N_VC-1:0]      nearly_full,
  output logic [N_VC*CW-1:0]   occupancy,
  output logic [N_VC-1:0]      credit_out,
  output logic                 overflow_err,
  output logic                 underflow_err,
  input  logic                 err_clr
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem    [N_VC][DEPTH];
  logic [PW-1:0]     wr_ptr [N_VC];
  logic [PW-1:0]     rd_ptr [N_VC];
  logic [CW-1:0]     count  [N_VC];
  logic [N_VC-1:0]   push_ok;
  logic [N_VC-1:0]   pop_ok;
  logic              ovf_now;
  logic              udf_now;
  logic              found;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full VC still accepts a push when the same VC pops, since a slot frees at the same edge.
  always_comb begin
    pop_ok  = '0;
    push_ok = '0;
    for (int v = 0; v < N_VC; v++) begin
      pop_ok[v]  = pop[v] && (count[v] != '0);
      push_ok[v] = push && (vc_id == VW'(v)) && ((count[v] < CW'(DEPTH)) || pop_ok[v]);
    end
    ovf_now = push && (push_ok == '0);
    udf_now = |(pop & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      credit_out    <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        if (push_ok[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop_ok[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        if (push_ok[v] && !pop_ok[v])      count[v] <= count[v] + CW'(1);
        else if (pop_ok[v] && !push_ok[v]) count[v] <= count[v] - CW'(1);
      end
      credit_out    <= pop_ok;
      overflow_err  <= ovf_now || (overflow_err && !err_clr);
      underflow_err <= udf_now || (underflow_err && !err_clr);
    end
  end

  // Storage is deliberately left unreset; counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int v = 0; v < N_VC; v++)
        if (push_ok[v]) mem[v][wr_ptr[v]] <= data_in;
    end
  end

  always_comb begin
    data_out = '0;
    found    = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (select[v] && !found) begin
        found = 1'b1;
        if (count[v] != '0) data_out = mem[v][rd_ptr[v]];
      end
    end
  end

  for (genvar g = 0; g < N_VC; g++) begin : g_flags
    assign empty[g]                = (count[g] == '0);
    assign nearly_empty[g]         = (count[g] == CW'(1));
    assign full[g]                 = (count[g] == CW'(DEPTH));
    assign nearly_full[g]          = (count[g] >= CW'(DEPTH - NF_TH));
    assign occupancy[g*CW +: CW]   = count[g];
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int v = 0; v < N_VC; v++)
        assert (count[v] <= CW'(DEPTH)) else $error("count overrun on vc %0d", v);
      assert ($onehot0(select)) else $error("select not one-hot");
      assert (!$isunknown({push, pop, select, vc_id})) else $error("X on control inputs");
    end
  end
`endif

endmodule

// File: tb/tb_nl_vc_buffers_param.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-per-VC model.
module tb_nl_vc_buffers_param;
  localparam int N_VC = 4, DEPTH = 4, DATA_W = 64, NF_TH = 1, CW = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                push = 1'b0;
  logic [1:0]          vc_id = '0;
  logic [DATA_W-1:0]   data_in = '0;
  logic [N_VC-1:0]     pop = '0;
  logic [N_VC-1:0]     select = '0;
  logic                err_clr = 1'b0;
  logic [DATA_W-1:0]   data_out;
  logic [N_VC-1:0]     empty, nearly_empty, full, nearly_full, credit_out;
  logic [N_VC*CW-1:0]  occupancy;
  logic                overflow_err, underflow_err;

  nl_vc_buffers_param #(.N_VC(N_VC), .DEPTH(DEPTH), .DATA_W(DATA_W), .NF_TH(NF_TH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .vc_id(vc_id), .data_in(data_in),
    .pop(pop), .select(select), .data_out(data_out), .empty(empty),
    .nearly_empty(nearly_empty), .full(full), .nearly_full(nearly_full),
    .occupancy(occupancy), .credit_out(credit_out), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: one queue of flits per VC plus registered side outputs.
  logic [DATA_W-1:0] q [N_VC][$];
  logic [N_VC-1:0]   m_cred = '0;
  logic              m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N_VC-1:0]    e_emp, e_ne, e_full, e_nf;
    logic [N_VC*CW-1:0] e_occ;
    logic [DATA_W-1:0]  e_dout;
    bit                 hit;
    e_dout = '0;
    hit = 0;
    for (int v = 0; v < N_VC; v++) begin
      e_emp[v]  = (q[v].size() == 0);
      e_ne[v]   = (q[v].size() == 1);
      e_full[v] = (q[v].size() == DEPTH);
      e_nf[v]   = ((DEPTH - q[v].size()) <= NF_TH);
      e_occ[v*CW +: CW] = CW'(q[v].size());
      if (select[v] && !hit) begin
        hit = 1;
        if (q[v].size() != 0) e_dout = q[v][0];
      end
    end
    chk("data_out", data_out, e_dout);
    chk("empty", 64'(empty), 64'(e_emp));
    chk("nearly_empty", 64'(nearly_empty), 64'(e_ne));
    chk("full", 64'(full), 64'(e_full));
    chk("nearly_full", 64'(nearly_full), 64'(e_nf));
    chk("occupancy", 64'(occupancy), 64'(e_occ));
    chk("credit_out", 64'(credit_out), 64'(m_cred));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("underflow_err", 64'(underflow_err), 64'(m_udf));
  endtask

  // One clock: drive inputs, predict from the spec rules, step, then compare.
  task automatic cyc(input logic r, input logic p, input logic [1:0] vc,
                     input logic [DATA_W-1:0] d, input logic [N_VC-1:0] pp,
                     input logic [N_VC-1:0] sel, input logic clr);
    logic [N_VC-1:0] pok;
    logic            acc;
    rst_n = r; push = p; vc_id = vc; data_in = d; pop = pp; select = sel; err_clr = clr;
    for (int v = 0; v < N_VC; v++) pok[v] = pp[v] && (q[v].size() > 0);
    acc = p && (int'(vc) < N_VC) && ((q[vc].size() < DEPTH) || pok[vc]);
    @(posedge clk);
    #1;
    if (!r) begin
      for (int v = 0; v < N_VC; v++) q[v].delete();
      m_cred = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      for (int v = 0; v < N_VC; v++) if (pok[v]) void'(q[v].pop_front());
      if (acc) q[vc].push_back(d);
      m_cred = pok;
      m_ovf  = (p && !acc) || (m_ovf && !clr);
      m_udf  = (|(pp & ~pok)) || (m_udf && !clr);
    end
    check_all();
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 4'h0, 4'h0, 0);
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_occ", 64'(occupancy), 64'h0);
    chk("rst_dout", data_out, 64'h0);

    // VC2 ordering, credits, nearly_empty
    cyc(1, 1, 2, 64'hA1, 4'h0, 4'b0100, 0);
    chk("vc2_first", data_out, 64'hA1);
    chk("vc2_ne", 64'(nearly_empty[2]), 64'h1);
    cyc(1, 1, 2, 64'hA2, 4'h0, 4'b0100, 0);
    cyc(1, 1, 2, 64'hA3, 4'h0, 4'b0100, 0);
    chk("vc2_occ3", 64'(occupancy[2*CW +: CW]), 64'd3);
    cyc(1, 0, 0, 0, 4'b0100, 4'b0100, 0);
    chk("vc2_pop1", data_out, 64'hA2);
    chk("vc2_cred", 64'(credit_out[2]), 64'h1);
    cyc(1, 0, 0, 0, 4'b0100, 4'b0100, 0);
    chk("vc2_pop2", data_out, 64'hA3);
    cyc(1, 0, 0, 0, 4'b0100, 4'b0100, 0);
    chk("vc2_empty", 64'(empty[2]), 64'h1);

    // VC0 fill, overflow, push-with-pop on full across wrap
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 64'hB0 + 64'(i), 4'h0, 4'b0001, 0);
      if (i == 2) chk("vc0_nf3", 64'(nearly_full[0]), 64'h1);
    end
    chk("vc0_full", 64'(full[0]), 64'h1);
    cyc(1, 1, 0, 64'hB4, 4'h0, 4'b0001, 0);
    chk("vc0_ovf", 64'(overflow_err), 64'h1);
    chk("vc0_occ4", 64'(occupancy[0 +: CW]), 64'd4);
    cyc(1, 1, 0, 64'hB5, 4'b0001, 4'b0001, 0);
    chk("vc0_pushpop_occ", 64'(occupancy[0 +: CW]), 64'd4);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 4'b0001, 4'b0001, 0);
    chk("vc0_wrap_tail", data_out, 64'hB5);
    cyc(1, 0, 0, 0, 4'b0001, 4'b0001, 0);

    // Pop of empty VC1 together with push: no fall-through
    cyc(1, 1, 1, 64'h55, 4'b0010, 4'b0010, 0);
    chk("vc1_udf", 64'(underflow_err), 64'h1);
    chk("vc1_nocred", 64'(credit_out[1]), 64'h0);
    chk("vc1_dout", data_out, 64'h55);

    // Simultaneous pops on all VCs
    cyc(1, 1, 0, 64'hC0, 4'h0, 4'b0001, 0);
    cyc(1, 1, 2, 64'hC2, 4'h0, 4'b0100, 0);
    cyc(1, 1, 3, 64'hC3, 4'h0, 4'b1000, 0);
    cyc(1, 1, 1, 64'hC1, 4'h0, 4'b0010, 0);
    cyc(1, 1, 0, 64'hD0, 4'hF, 4'b0010, 0);
    chk("all_cred", 64'(credit_out), 64'hF);
    chk("vc1_next", data_out, 64'hC1);

    // Error clear, then clear racing a new overflow
    cyc(1, 0, 0, 0, 4'h0, 4'h0, 1);
    chk("clr_ovf", 64'(overflow_err), 64'h0);
    chk("clr_udf", 64'(underflow_err), 64'h0);
    while (q[3].size() < DEPTH) cyc(1, 1, 3, 64'hE0 + 64'(q[3].size()), 4'h0, 4'b1000, 0);
    cyc(1, 1, 3, 64'hEF, 4'h0, 4'b1000, 1);
    chk("clr_vs_set", 64'(overflow_err), 64'h1);

    // Reset mid-traffic with VC3 holding three flits
    cyc(1, 0, 0, 0, 4'b1000, 4'b1000, 0);
    chk("vc3_occ3", 64'(occupancy[3*CW +: CW]), 64'd3);
    cyc(0, 1, 3, 64'h99, 4'b1000, 4'b1000, 0);
    chk("mid_rst_empty", 64'(empty), 64'hF);
    chk("mid_rst_occ", 64'(occupancy), 64'h0);
    chk("mid_rst_dout", data_out, 64'h0);
    cyc(1, 1, 3, 64'h77, 4'h0, 4'b1000, 0);
    chk("post_rst_push", data_out, 64'h77);
    cyc(1, 0, 0, 0, 4'b1000, 4'b1000, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      int s;
      logic [N_VC-1:0] sel;
      s = $urandom_range(0, 4);
      sel = (s == 0) ? 4'h0 : 4'(1 << (s - 1));
      cyc(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, 4'($urandom & $urandom), sel, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
